hall_debounce: RTL and testbench

Input conditioner for the four Hall-effect sensor lines of the unlock mechanism. It sits directly upstream of the register file and produces clean, debounced levels that drive the register file's `H1in`..`H4in` inputs, which are sampled into registers 1–4 every cycle. The raw sensor pins are asynchronous and bouncy. This block synchronizes each channel, filters it with a per-channel stability counter, and emits one-cycle edge pulses.

---
 rtl/hall_pkg.sv | 22 ++
 rtl/hall_debounce_chan.sv | 75 +++++++
 rtl/hall_debounce.sv | 54 +++++
 tb/tb_hall_debounce.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hall_pkg.sv
// rtl/hall_pkg.sv - shared constants and types for the Hall sensor debouncer
package hall_pkg;

   localparam int HALL_CHANNELS         = 4;
   localparam int HALL_DEBOUNCE_DEFAULT = 50000;

   localparam int HALL_H1 = 0;
   localparam int HALL_H2 = 1;
   localparam int HALL_H3 = 2;
   localparam int HALL_H4 = 3;

   typedef enum logic {
      CH_IDLE    = 1'b0,
      CH_PENDING = 1'b1
   } chan_state_e;

   // Counter only needs to reach cycles-1; keep at least one bit for cycles == 1.
   function automatic int hall_cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/hall_debounce_chan.sv
// rtl/hall_debounce_chan.sv - one channel: 2-flop synchronizer, stability counter, level and edge pulses
module hall_debounce_chan
   import hall_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = HALL_DEBOUNCE_DEFAULT
) (
   input  logic clock,
   input  logic ctrl_reset,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int              CW      = hall_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic          lvl_q, lvl_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   chan_state_e   state;

   always_comb begin
      s1_d   = raw;
      s2_d   = s1_q;
      lvl_d  = lvl_q;
      cnt_d  = '0;
      rise_d = 1'b0;
      fall_d = 1'b0;
      state  = (s2_q != lvl_q) ? CH_PENDING : CH_IDLE;
      case (state)
         CH_IDLE: begin
            cnt_d = '0;
         end
         CH_PENDING: begin
            // The pulse is registered alongside lvl so both appear in the same cycle.
            if (cnt_q == CNT_MAX) begin
               lvl_d  = s2_q;
               cnt_d  = '0;
               rise_d = s2_q;
               fall_d = ~s2_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         lvl_q  <= 1'b0;
         cnt_q  <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         lvl_q  <= lvl_d;
         cnt_q  <= cnt_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign level = lvl_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/hall_debounce.sv
// rtl/hall_debounce.sv - four-channel Hall sensor debouncer with edge pulses
// Optional sticky rising-edge event latch under HALL_EVENT_LATCH_EN.
module hall_debounce
   import hall_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = HALL_DEBOUNCE_DEFAULT
) (
   input  logic                     clock,
   input  logic                     ctrl_reset,
   input  logic [HALL_CHANNELS-1:0] hall_raw,
   output logic [HALL_CHANNELS-1:0] hall_level,
   output logic [HALL_CHANNELS-1:0] hall_rise,
   output logic [HALL_CHANNELS-1:0] hall_fall
`ifdef HALL_EVENT_LATCH_EN
   ,
   input  logic                     event_clear,
   output logic [HALL_CHANNELS-1:0] hall_event
`endif
);

   for (genvar i = 0; i < HALL_CHANNELS; i++) begin : g_chan
      hall_debounce_chan #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .clock      (clock),
         .ctrl_reset (ctrl_reset),
         .raw        (hall_raw[i]),
         .level      (hall_level[i]),
         .rise       (hall_rise[i]),
         .fall       (hall_fall[i])
      );
   end

`ifdef HALL_EVENT_LATCH_EN
   logic [HALL_CHANNELS-1:0] event_q, event_d;

   // A rise arriving in the same cycle as a clear still gets recorded.
   always_comb begin
      event_d = event_clear ? '0 : event_q;
      event_d = event_d | hall_rise;
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         event_q <= '0;
      end else begin
         event_q <= event_d;
      end
   end

   assign hall_event = event_q;
`endif

endmodule

// File: tb/tb_hall_debounce.sv
// tb/tb_hall_debounce.sv - self-checking bench for hall_debounce with DEBOUNCE_CYCLES = 4
module tb_hall_debounce;
   import hall_pkg::*;

   localparam int DC = 4;

   typedef struct {
      logic [3:0] raw;
      int         hold;
      logic [3:0] lvl;
      logic [3:0] rise;
      logic [3:0] fall;
   } vec_t;

   logic       clock;
   logic       ctrl_reset;
   logic [3:0] hall_raw;
   logic [3:0] hall_level;
   logic [3:0] hall_rise;
   logic [3:0] hall_fall;
`ifdef HALL_EVENT_LATCH_EN
   logic       event_clear;
   logic [3:0] hall_event;
`endif

   int checks;
   int failures;
   int rise_cnt [4];
   int fall_cnt [4];
   vec_t vecs [$];
   vec_t sb   [$];

   hall_debounce #(
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .hall_raw   (hall_raw),
      .hall_level (hall_level),
      .hall_rise  (hall_rise),
      .hall_fall  (hall_fall)
`ifdef HALL_EVENT_LATCH_EN
      ,
      .event_clear(event_clear),
      .hall_event (hall_event)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      for (int i = 0; i < 4; i++) begin
         rise_cnt[i] += int'(hall_rise[i]);
         fall_cnt[i] += int'(hall_fall[i]);
      end
      if ((hall_rise & hall_fall) != 4'h0) begin
         failures++;
         $display("FAIL rise_fall_overlap: rise=%h fall=%h required no common bit", hall_rise, hall_fall);
      end
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) begin
         rise_cnt[i] = 0;
         fall_cnt[i] = 0;
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      logic [3:0] rm, fm, multi;
      hall_raw = v.raw;
      clear_counts();
      sb.push_back(v);
      repeat (v.hold) @(negedge clock);
      e = sb.pop_front();
      rm = '0; fm = '0; multi = '0;
      for (int i = 0; i < 4; i++) begin
         rm[i]    = (rise_cnt[i] != 0);
         fm[i]    = (fall_cnt[i] != 0);
         multi[i] = (rise_cnt[i] > 1) || (fall_cnt[i] > 1);
      end
      chk($sformatf("vec%0d_level", idx), hall_level, e.lvl);
      chk($sformatf("vec%0d_rise", idx), rm, e.rise);
      chk($sformatf("vec%0d_fall", idx), fm, e.fall);
      chk($sformatf("vec%0d_single_pulse", idx), multi, 4'h0);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      clear_counts();
      ctrl_reset = 1'b1;
      hall_raw   = 4'hF;
`ifdef HALL_EVENT_LATCH_EN
      event_clear = 1'b0;
`endif

      // Reset values with the raw inputs high.
      repeat (3) @(negedge clock);
      chk("reset_level", hall_level, 4'h0);
      chk("reset_rise", hall_rise, 4'h0);
      chk("reset_fall", hall_fall, 4'h0);
`ifdef HALL_EVENT_LATCH_EN
      chk("reset_event", hall_event, 4'h0);
`endif
      ctrl_reset = 1'b0;
      repeat (DC + 1) @(negedge clock);
      chk("post_reset_level_edge4", hall_level, 4'h0);
      @(negedge clock);
      chk("post_reset_level_edge5", hall_level, 4'hF);
      chk("post_reset_rise_edge5", hall_rise, 4'hF);
      @(negedge clock);
      chk("post_reset_rise_gone", hall_rise, 4'h0);
      chk("post_reset_level_hold", hall_level, 4'hF);

      // Vector table: raw value, cycles held, expected level and pulse masks.
      vecs.push_back('{4'h0, 8, 4'h0, 4'h0, 4'hF});
      vecs.push_back('{4'h4, 8, 4'h4, 4'h4, 4'h0});
      vecs.push_back('{4'h0, 8, 4'h0, 4'h0, 4'h4});
      vecs.push_back('{4'h1, 3, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{4'h0, 8, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{4'h1, 1, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{4'h0, 1, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{4'h1, 8, 4'h1, 4'h1, 4'h0});
      vecs.push_back('{4'h0, 8, 4'h0, 4'h0, 4'h1});
      vecs.push_back('{4'hA, 8, 4'hA, 4'hA, 4'h0});
      vecs.push_back('{4'h5, 8, 4'h5, 4'h5, 4'hA});
      vecs.push_back('{4'h0, 8, 4'h0, 4'h0, 4'h5});
      foreach (vecs[k]) apply(vecs[k], k);

      // Exact latency of a single-channel step on H3.
      hall_raw = 4'h1 << HALL_H3;
      repeat (DC + 1) @(negedge clock);
      chk("h3_level_edge4", hall_level, 4'h0);
      @(negedge clock);
      chk("h3_level_edge5", hall_level, 4'h4);
      chk("h3_rise_edge5", hall_rise, 4'h4);
      @(negedge clock);
      chk("h3_rise_gone", hall_rise, 4'h0);
      apply('{4'h0, 8, 4'h0, 4'h0, 4'h4}, 100);

      // Reset arriving on edge 3 of a pending rise on H2.
      hall_raw = 4'h1 << HALL_H2;
      repeat (3) @(negedge clock);
      ctrl_reset = 1'b1;
      @(negedge clock);
      chk("midreset_level", hall_level, 4'h0);
      ctrl_reset = 1'b0;
      repeat (DC + 1) @(negedge clock);
      chk("midreset_level_edge4", hall_level, 4'h0);
      @(negedge clock);
      chk("midreset_level_edge5", hall_level, 4'h2);
      chk("midreset_rise_edge5", hall_rise, 4'h2);
      apply('{4'h0, 8, 4'h0, 4'h0, 4'h2}, 101);

`ifdef HALL_EVENT_LATCH_EN
      @(negedge clock);
      event_clear = 1'b1;
      @(negedge clock);
      event_clear = 1'b0;
      chk("event_cleared_start", hall_event, 4'h0);
      apply('{4'h8, 8, 4'h8, 4'h8, 4'h0}, 200);
      chk("event_h4_set", hall_event, 4'h8);
      apply('{4'h0, 8, 4'h0, 4'h0, 4'h8}, 201);
      chk("event_h4_hold_after_fall", hall_event, 4'h8);
      event_clear = 1'b1;
      @(negedge clock);
      chk("event_clear", hall_event, 4'h0);
      hall_raw = 4'h1 << HALL_H1;
      repeat (DC + 2) @(negedge clock);
      chk("event_h1_rise_pulse", hall_rise, 4'h1);
      @(negedge clock);
      chk("event_set_wins", hall_event, 4'h1);
      @(negedge clock);
      chk("event_clear_held", hall_event, 4'h0);
      event_clear = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
